// File: rtl/dac_spi_tx.sv
// dac_spi_tx: samples the DDS sine output on a fixed tick and ships it as one 16-bit SPI mode-0 frame.
// Latency: dac_cs_n falls the cycle after the tick; cs low for 33*CLK_DIV cycles, then one frame_done cycle.
// Backpressure: none; a tick arriving while busy is dropped and recorded in the sticky overrun flag.
module dac_spi_tx #(
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_DIV = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [9:0] sample_in,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_mosi,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [CW-1:0]   r_hcnt;
  logic [3:0]      r_bit;
  logic [14:0]     r_shift;   // bits still to be sent after the one on dac_mosi
  logic            r_cs_n;
  logic            r_sclk;
  logic            r_mosi;
  logic            r_busy;
  logic            r_done;
  logic            r_ovr;

  logic            w_tick;
  logic            w_hc_last;
  logic [15:0]     w_word;

  assign w_tick    = enable && (r_timer == TW'(SAMPLE_DIV - 1));
  assign w_hc_last = (r_hcnt == CW'(CLK_DIV - 1));
  assign w_word    = {4'b0011, sample_in, 2'b00};

  assign dac_cs_n   = r_cs_n;
  assign dac_sclk   = r_sclk;
  assign dac_mosi   = r_mosi;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign overrun    = r_ovr;

  // Sample timer: free-runs 0..SAMPLE_DIV-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!enable || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Sticky overrun: set by a tick that lands while a frame is in flight, cleared by disabling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
    end else if (!enable) begin
      r_ovr <= 1'b0;
    end else if (w_tick && r_busy) begin
      r_ovr <= 1'b1;
    end
  end

  // Frame FSM: IDLE -> SHIFT (16 low/high SCLK phases) -> HOLD (cs tail) -> DONE (pulse) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_tick) begin
            r_shift <= w_word[14:0];
            r_mosi  <= w_word[15];
            r_cs_n  <= 1'b0;
            r_hcnt  <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_hc_last) begin
            r_hcnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // Falling edge: present the next bit, or finish after the 16th high phase.
              r_sclk <= 1'b0;
              if (r_bit == 4'd15) begin
                r_state <= S_HOLD;
              end else begin
                r_bit   <= r_bit + 4'd1;
                r_mosi  <= r_shift[14];
                r_shift <= {r_shift[13:0], 1'b0};
              end
            end
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_hc_last) begin
            r_hcnt  <= '0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        default: begin
          // Done cycle still counts as busy so a coincident tick is dropped.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
